video_mem_scheduler: RTL and testbench
======================================

// Module: video_mem_scheduler
// PURPOSE
//  Schedules a single-port synchronous frame-buffer RAM between display scan-out and a host port.
//  Sits downstream of video_sync_generator, consuming its registered blank_n/h_sync/v_sync.
//  Display reads are strict priority and deadline-bound; host reads and writes use blanking slots only.
//  Emits pixel data plus syncs delayed to the same 2-cycle latency.
// PARAMETERS
//  DATA_W    8       pixel / host data width (RGB332)
//  ADDR_W    19      frame-buffer address width
//  FB_DEPTH  307200  pixels per frame (640x480); display address wraps at FB_DEPTH-1
// PORTS
//  in_vga_clk       in   1       pixel clock; all flops on rising edge
//  in_reset         in   1       asynchronous, active-high reset
//  in_blank_n       in   1       from sync generator; 1 = active pixel this cycle
//  in_h_sync        in   1       from sync generator, active low
//  in_v_sync        in   1       from sync generator, active low
//  in_host_req      in   1       host request; level, held until out_host_ack
//  in_host_we       in   1       1 = write, 0 = read; held with req
//  in_host_addr     in   ADDR_W  host address; held with req
//  in_host_wdata    in   DATA_W  host write data; held with req
//  out_host_ack     out  1       one-cycle pulse: access complete
//  out_host_rdata   out  DATA_W  read data; valid while out_host_ack=1, held afterwards
//  out_mem_en       out  1       RAM enable (registered)
//  out_mem_we       out  1       RAM write enable (registered)
//  out_mem_addr     out  ADDR_W  RAM address (registered)
//  out_mem_wdata    out  DATA_W  RAM write data (registered)
//  in_mem_rdata     in   DATA_W  RAM read data, 1 cycle after the enable edge
//  out_pix_data     out  DATA_W  pixel aligned with out_blank_n_d; 0 when blanked
//  out_blank_n_d    out  1       in_blank_n delayed by 2 cycles
//  out_h_sync_d     out  1       in_h_sync delayed by 2 cycles
//  out_v_sync_d     out  1       in_v_sync delayed by 2 cycles
// BEHAVIOUR
//  - Reset values: all mem outputs 0; ack 0; rdata 0; pix_data 0; blank_n_d 0; h/v_sync_d 1; disp_addr 0; FSM IDLE.
//  - Slot rule: one RAM issuer per edge. in_blank_n=1 gives the display the slot, unconditionally.
//  - Display: at edge k with blank_n=1, out_mem_en=1, we=0, addr=disp_addr; disp_addr++ (FB_DEPTH-1 -> 0).
//  - Display pixel: in_mem_rdata is captured into out_pix_data at edge k+2 with out_blank_n_d=1, so latency is 2.
//  - Frame restart: in_v_sync=0 forces disp_addr to 0. v_sync has priority over increment (not expected with blank_n=1).
//  - Host FSM, IDLE -> WAIT -> DONE:
//    IDLE: in_host_req=1 and in_blank_n=0 at edge k: load mem regs with host fields, en=1. Go to WAIT.
//    WAIT (edge k+1): mem regs idle. Go to DONE.
//    DONE (edge k+2): capture in_mem_rdata (read only), pulse out_host_ack. Go to IDLE.
//  - Writes use the same 2-cycle ack latency. A new request is sampled no earlier than edge k+3.
//  - Host must drop req in the ack cycle or present the next request; req=1 at IDLE after ack is a new access.
//  - Host req during active video: held off, no timeout. Accepted at the first edge with blank_n=0.
//  - Idle slot (no display, no host): out_mem_en=0, out_mem_we=0; addr/wdata hold their values.
//  - In-flight host access is never preempted: WAIT/DONE occupy no RAM slot.
//  - Reset mid-operation: FSM returns to IDLE, no ack is issued, the access is abandoned, and the host re-issues.
//  - Arithmetic: disp_addr is ADDR_W bits, compared to FB_DEPTH-1 for wrap. No other width conversion.
// STRUCTURE
//  - Package vga_mem_pkg: DATA_W/ADDR_W/FB_DEPTH defaults, host FSM state localparams (2-bit encoding).
//  - Sub-module sync_delay_pipe (parameter DEPTH=2, WIDTH=3, reset value parameter): blank_n/h_sync/v_sync delay.
//  - Top: slot select, display address counter, host FSM, pixel capture register.
// TESTING
//  - Reset: hold in_reset 3 cycles, mid-frame. All outputs at reset values; h/v_sync_d=1; out_mem_en=0.
//  - Scan-out: RAM preloaded mem[a]=a[7:0]; v_sync low, then 640 blank_n cycles.
//    Required: addrs 0..639 in order; out_pix_data=0x00..0x7F... (a[7:0]) 2 cycles later with blank_n_d=1.
//  - Host write then read in blanking: write 0x100=0xA5 gives one we pulse and ack at +2 edges; read 0x100 gives rdata 0xA5.
//  - Host req raised 5 cycles before blank_n falls: no RAM host access while blank_n=1.
//    Required: accept at first blank edge, ack 2 edges later, display addresses contiguous.
//  - Wrap with FB_DEPTH=16: 20 active cycles, no v_sync. Addresses 0..15,0..3; v_sync low then restarts at 0.
//  - Reset during WAIT of a host read: no ack ever; FSM IDLE; next request completes normally.

Source files
------------

// File: rtl/vga_mem_pkg.sv
// rtl/vga_mem_pkg.sv - shared widths, frame size and host FSM encoding for the frame-buffer scheduler
package vga_mem_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 19;
  localparam int FB_DEPTH_DEF = 307200;

  // Host access sequencing: one issue slot, then two slots waiting on the RAM read pipe
  typedef enum logic [1:0] {
    HOST_IDLE = 2'b00,
    HOST_WAIT = 2'b01,
    HOST_DONE = 2'b10
  } host_state_t;

  // Reset value of the {blank_n, h_sync, v_sync} bundle: blanked, syncs inactive (high)
  localparam logic [2:0] SYNC_RESET_VAL = 3'b011;

endpackage

// File: rtl/sync_delay_pipe.sv
// rtl/sync_delay_pipe.sv - fixed-depth register pipe used to align sync/blank with pixel data
module sync_delay_pipe #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the bundle one stage per clock; reset loads the inactive pattern everywhere
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_data = stage[DEPTH-1];

endmodule

// File: rtl/video_mem_scheduler.sv
// rtl/video_mem_scheduler.sv - single-port frame-buffer arbiter: display scan-out first, host in blanking
module video_mem_scheduler
  import vga_mem_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int FB_DEPTH = FB_DEPTH_DEF
) (
  input  logic              in_vga_clk,
  input  logic              in_reset,
  input  logic              in_blank_n,
  input  logic              in_h_sync,
  input  logic              in_v_sync,
  input  logic              in_host_req,
  input  logic              in_host_we,
  input  logic [ADDR_W-1:0] in_host_addr,
  input  logic [DATA_W-1:0] in_host_wdata,
  output logic              out_host_ack,
  output logic [DATA_W-1:0] out_host_rdata,
  output logic              out_mem_en,
  output logic              out_mem_we,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_wdata,
  input  logic [DATA_W-1:0] in_mem_rdata,
  output logic [DATA_W-1:0] out_pix_data,
  output logic              out_blank_n_d,
  output logic              out_h_sync_d,
  output logic              out_v_sync_d
);

  localparam logic [ADDR_W-1:0] DISP_LAST = ADDR_W'(FB_DEPTH - 1);

  host_state_t       host_state;
  logic              host_we_q;
  logic [ADDR_W-1:0] disp_addr;
  logic [2:0]        sync_q;
  logic [2:0]        sync_d;
  logic              pix_valid_q;
  logic              disp_slot;
  logic              host_slot;

  // Active video owns the RAM outright; the host only gets a slot while blanked and idle
  assign disp_slot = in_blank_n;
  assign host_slot = !in_blank_n && in_host_req && (host_state == HOST_IDLE);

  // RAM command registers: one issuer per edge, address/data hold on idle slots
  always_ff @(posedge in_vga_clk or posedge in_reset) begin
    if (in_reset) begin
      out_mem_en    <= 1'b0;
      out_mem_we    <= 1'b0;
      out_mem_addr  <= '0;
      out_mem_wdata <= '0;
    end else if (disp_slot) begin
      out_mem_en   <= 1'b1;
      out_mem_we   <= 1'b0;
      out_mem_addr <= disp_addr;
    end else if (host_slot) begin
      out_mem_en    <= 1'b1;
      out_mem_we    <= in_host_we;
      out_mem_addr  <= in_host_addr;
      out_mem_wdata <= in_host_wdata;
    end else begin
      out_mem_en <= 1'b0;
      out_mem_we <= 1'b0;
    end
  end

  // Scan-out address: frame sync restarts it, otherwise it advances once per active pixel
  always_ff @(posedge in_vga_clk or posedge in_reset) begin
    if (in_reset) begin
      disp_addr <= '0;
    end else if (!in_v_sync) begin
      disp_addr <= '0;
    end else if (in_blank_n) begin
      disp_addr <= (disp_addr == DISP_LAST) ? '0 : disp_addr + 1'b1;
    end
  end

  // Host FSM: issue, wait out the RAM latency, then ack (and capture read data)
  always_ff @(posedge in_vga_clk or posedge in_reset) begin
    if (in_reset) begin
      host_state     <= HOST_IDLE;
      host_we_q      <= 1'b0;
      out_host_ack   <= 1'b0;
      out_host_rdata <= '0;
    end else begin
      out_host_ack <= 1'b0;
      case (host_state)
        HOST_IDLE: begin
          if (host_slot) begin
            host_state <= HOST_WAIT;
            host_we_q  <= in_host_we;
          end
        end
        HOST_WAIT: host_state <= HOST_DONE;
        HOST_DONE: begin
          out_host_ack <= 1'b1;
          if (!host_we_q) out_host_rdata <= in_mem_rdata;
          host_state <= HOST_IDLE;
        end
        default: host_state <= HOST_IDLE;
      endcase
    end
  end

  // Sample syncs alongside the RAM command, then track which read slots carry a pixel
  always_ff @(posedge in_vga_clk or posedge in_reset) begin
    if (in_reset) begin
      sync_q       <= SYNC_RESET_VAL;
      pix_valid_q  <= 1'b0;
      out_pix_data <= '0;
    end else begin
      sync_q       <= {in_blank_n, in_h_sync, in_v_sync};
      pix_valid_q  <= sync_q[2];
      out_pix_data <= pix_valid_q ? in_mem_rdata : '0;
    end
  end

  // Two further stages bring the sampled syncs level with the captured pixel
  sync_delay_pipe #(
    .DEPTH     (2),
    .WIDTH     (3),
    .RESET_VAL (SYNC_RESET_VAL)
  ) u_sync_pipe (
    .in_clk   (in_vga_clk),
    .in_reset (in_reset),
    .in_data  (sync_q),
    .out_data (sync_d)
  );

  assign out_blank_n_d = sync_d[2];
  assign out_h_sync_d  = sync_d[1];
  assign out_v_sync_d  = sync_d[0];

endmodule

// File: tb/tb_video_mem_scheduler.sv
// tb/tb_video_mem_scheduler.sv - self-checking bench for video_mem_scheduler
module tb_video_mem_scheduler;

  logic        clk = 1'b0;
  logic        rst, blank_n, h_sync, v_sync, host_req, host_we;
  logic [18:0] host_addr;
  logic [7:0]  host_wdata, mem_rdata;

  logic        ack, mem_en, mem_we, bd, hd, vd;
  logic [7:0]  rdata, mem_wdata, pix;
  logic [18:0] mem_addr;

  logic        w_ack, w_mem_en, w_mem_we, w_bd, w_hd, w_vd;
  logic [7:0]  w_rdata, w_mem_wdata, w_pix;
  logic [18:0] w_mem_addr;

  logic [7:0]  ram    [0:524287];
  logic [7:0]  shadow [0:4095];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  video_mem_scheduler u_dut (
    .in_vga_clk(clk), .in_reset(rst), .in_blank_n(blank_n), .in_h_sync(h_sync), .in_v_sync(v_sync),
    .in_host_req(host_req), .in_host_we(host_we), .in_host_addr(host_addr), .in_host_wdata(host_wdata),
    .out_host_ack(ack), .out_host_rdata(rdata), .out_mem_en(mem_en), .out_mem_we(mem_we),
    .out_mem_addr(mem_addr), .out_mem_wdata(mem_wdata), .in_mem_rdata(mem_rdata),
    .out_pix_data(pix), .out_blank_n_d(bd), .out_h_sync_d(hd), .out_v_sync_d(vd)
  );

  video_mem_scheduler #(.FB_DEPTH(16)) u_wrap (
    .in_vga_clk(clk), .in_reset(rst), .in_blank_n(blank_n), .in_h_sync(h_sync), .in_v_sync(v_sync),
    .in_host_req(host_req), .in_host_we(host_we), .in_host_addr(host_addr), .in_host_wdata(host_wdata),
    .out_host_ack(w_ack), .out_host_rdata(w_rdata), .out_mem_en(w_mem_en), .out_mem_we(w_mem_we),
    .out_mem_addr(w_mem_addr), .out_mem_wdata(w_mem_wdata), .in_mem_rdata(mem_rdata),
    .out_pix_data(w_pix), .out_blank_n_d(w_bd), .out_h_sync_d(w_hd), .out_v_sync_d(w_vd)
  );

  // Frame-buffer RAM: synchronous, read data one cycle after the enable edge
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Directed host-port vectors, applied in blanking one edge per row
  typedef struct {
    logic        req, we;
    logic [18:0] addr;
    logic [7:0]  wdata;
    logic        e_en, e_we;
    logic [18:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_ack;
    logic [7:0]  e_rdata;
  } vec_t;
  vec_t vt [7];

  // Reference model: what happened at each edge, looked back on two edges later
  typedef struct {
    logic blank, h, v, issue, we;
    logic [7:0] rval;
  } rec_t;
  rec_t r1, r2;
  int   m_d;
  logic e_en, e_we, e_ack, e_bd, e_hd, e_vd;
  int   e_addr;
  logic [7:0] e_wdata, e_rdata, e_pix;

  task automatic model_reset();
    r1 = '{blank: 1'b0, h: 1'b1, v: 1'b1, issue: 1'b0, we: 1'b0, rval: 8'h00};
    r2 = r1;
    m_d = 0; e_addr = 0; e_wdata = 8'h00; e_rdata = 8'h00;
  endtask

  task automatic model_edge();
    rec_t cur;
    cur = '{blank: blank_n, h: h_sync, v: v_sync, issue: 1'b0, we: 1'b0, rval: 8'h00};
    if (blank_n) begin
      e_en = 1'b1; e_we = 1'b0; e_addr = m_d;
      cur.rval = shadow[m_d];
    end else if (host_req && !(r1.issue || r2.issue)) begin
      e_en = 1'b1; e_we = host_we; e_addr = int'(host_addr); e_wdata = host_wdata;
      cur.issue = 1'b1; cur.we = host_we; cur.rval = shadow[host_addr];
      if (host_we) shadow[host_addr] = host_wdata;
    end else begin
      e_en = 1'b0; e_we = 1'b0;
    end
    e_ack = r2.issue;
    if (r2.issue && !r2.we) e_rdata = r2.rval;
    e_pix = r2.blank ? r2.rval : 8'h00;
    e_bd = r2.blank; e_hd = r2.h; e_vd = r2.v;
    if (!v_sync) m_d = 0;
    else if (blank_n) m_d = (m_d == 307199) ? 0 : m_d + 1;
    r2 = r1;
    r1 = cur;
  endtask

  initial begin
    logic req_active;
    int   base;

    vt[0] = '{1'b1, 1'b1, 19'h100, 8'hA5, 1'b1, 1'b1, 19'h100, 8'hA5, 1'b0, 8'h00};
    vt[1] = '{1'b1, 1'b1, 19'h100, 8'hA5, 1'b0, 1'b0, 19'h100, 8'hA5, 1'b0, 8'h00};
    vt[2] = '{1'b1, 1'b1, 19'h100, 8'hA5, 1'b0, 1'b0, 19'h100, 8'hA5, 1'b1, 8'h00};
    vt[3] = '{1'b1, 1'b0, 19'h100, 8'h00, 1'b1, 1'b0, 19'h100, 8'h00, 1'b0, 8'h00};
    vt[4] = '{1'b1, 1'b0, 19'h100, 8'h00, 1'b0, 1'b0, 19'h100, 8'h00, 1'b0, 8'h00};
    vt[5] = '{1'b1, 1'b0, 19'h100, 8'h00, 1'b0, 1'b0, 19'h100, 8'h00, 1'b1, 8'hA5};
    vt[6] = '{1'b0, 1'b0, 19'h100, 8'h00, 1'b0, 1'b0, 19'h100, 8'h00, 1'b0, 8'hA5};

    for (int a = 0; a < 524288; a++) ram[a] = a[7:0];

    rst = 1'b1; blank_n = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset mid-frame with syncs driven low
    blank_n = 1'b1;
    repeat (6) step();
    rst = 1'b1; h_sync = 1'b0; v_sync = 1'b0;
    repeat (3) step();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_pix", pix, 0);
    check("rst_blank_d", bd, 0);
    check("rst_h_sync_d", hd, 1);
    check("rst_v_sync_d", vd, 1);
    rst = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
    step();
    check("post_rst_disp_addr", mem_addr, 0);
    check("post_rst_disp_en", mem_en, 1);
    blank_n = 1'b0;
    step();

    // Scan-out of one 640-pixel line
    v_sync = 1'b0; step(); v_sync = 1'b1;
    for (int i = 0; i < 642; i++) begin
      blank_n = (i < 640);
      step();
      if (i < 640) begin
        check("scan_addr", mem_addr, i);
        check("scan_en", mem_en, 1);
      end
      if (i >= 2) begin
        check("scan_pix", pix, (i - 2) & 255);
        check("scan_blank_d", bd, 1);
      end
    end
    step();
    check("scan_end_pix", pix, 0);
    check("scan_end_blank_d", bd, 0);

    // Host write then read in blanking
    for (int i = 0; i < 7; i++) begin
      host_req = vt[i].req; host_we = vt[i].we; host_addr = vt[i].addr; host_wdata = vt[i].wdata;
      step();
      check("vec_en", mem_en, vt[i].e_en);
      check("vec_we", mem_we, vt[i].e_we);
      check("vec_addr", mem_addr, vt[i].e_addr);
      check("vec_wdata", mem_wdata, vt[i].e_wdata);
      check("vec_ack", ack, vt[i].e_ack);
      check("vec_rdata", rdata, vt[i].e_rdata);
    end
    check("vec_ram_written", ram[19'h100], 8'hA5);

    // Host request held off by active video
    v_sync = 1'b0; step(); v_sync = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 19'h200; host_wdata = 8'h3C;
    blank_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_disp_addr", mem_addr, i);
      check("hold_no_host_we", mem_we, 0);
    end
    blank_n = 1'b0;
    step();
    check("hold_accept_en", mem_en, 1);
    check("hold_accept_we", mem_we, 1);
    check("hold_accept_addr", mem_addr, 19'h200);
    step();
    check("hold_wait_ack", ack, 0);
    step();
    check("hold_done_ack", ack, 1);
    host_req = 1'b0; blank_n = 1'b1;
    step();
    check("hold_resume_addr", mem_addr, 5);
    check("hold_ram_written", ram[19'h200], 8'h3C);
    blank_n = 1'b0;
    step();

    // Display address wrap with a 16-pixel frame
    v_sync = 1'b0; step(); v_sync = 1'b1;
    blank_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("wrap_addr", w_mem_addr, i % 16);
    end
    blank_n = 1'b0; v_sync = 1'b0; step();
    v_sync = 1'b1; blank_n = 1'b1; step();
    check("wrap_restart_addr", w_mem_addr, 0);
    blank_n = 1'b0; step();

    // Reset while a host read is in flight
    host_req = 1'b1; host_we = 1'b0; host_addr = 19'h100; host_wdata = 8'h00;
    step();
    check("abort_issue_en", mem_en, 1);
    rst = 1'b1; host_req = 1'b0;
    step();
    check("abort_rst_ack", ack, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_ack", ack, 0);
    end
    host_req = 1'b1;
    step();
    check("reissue_en", mem_en, 1);
    step();
    check("reissue_wait_ack", ack, 0);
    step();
    check("reissue_ack", ack, 1);
    check("reissue_rdata", rdata, 8'hA5);
    host_req = 1'b0;
    step();

    // Randomised traffic against the reference model
    rst = 1'b1; step(); rst = 1'b0;
    for (int a = 0; a < 4096; a++) shadow[a] = ram[a];
    model_reset();
    req_active = 1'b0;
    base = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) blank_n = ~blank_n;
      v_sync = ($urandom_range(63) != 0);
      h_sync = ($urandom_range(15) != 0);
      if (!req_active && $urandom_range(2) == 0) begin
        req_active = 1'b1;
        host_we    = $urandom_range(1);
        host_addr  = 19'($urandom_range(4095));
        host_wdata = 8'($urandom);
      end
      host_req = req_active;
      model_edge();
      step();
      check("rnd_en", mem_en, e_en);
      check("rnd_we", mem_we, e_we);
      check("rnd_addr", mem_addr, e_addr);
      check("rnd_wdata", mem_wdata, e_wdata);
      check("rnd_ack", ack, e_ack);
      check("rnd_rdata", rdata, e_rdata);
      check("rnd_pix", pix, e_pix);
      check("rnd_blank_d", bd, e_bd);
      check("rnd_h_sync_d", hd, e_hd);
      check("rnd_v_sync_d", vd, e_vd);
      if (e_ack) req_active = 1'b0;
      base++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
